// File: rtl/onehot_encoder_pipe.sv
// onehot_encoder_pipe: registered one-hot / thermometer / ring-rotate code generator with valid/ready handshakes
module onehot_encoder_pipe #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  ip,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] op,
  output logic             err,
  output logic [OUT_W-1:0] ring
);
  localparam int CW = IN_W > $clog2(OUT_W) + 1 ? IN_W : $clog2(OUT_W) + 1;
  if (OUT_W < 2 || OUT_W > (1 << IN_W)) begin : g_bad_width
    $error("onehot_encoder_pipe: OUT_W must lie in 2..2**IN_W");
  end
  logic [CW-1:0]      ip_w;
  logic               range_err, bad, accept;
  logic [OUT_W-1:0]   code, rot;
  logic [2*OUT_W-1:0] dbl;
  always_comb begin
    ip_w      = CW'(ip);
    range_err = ip_w >= CW'(OUT_W);
    bad       = range_err || mode == 2'b11;
    // upper half of the doubled ring shifted left is the left rotation
    dbl       = {ring, ring} << ip;
    rot       = dbl[2*OUT_W-1:OUT_W];
    code      = bad ? '0 :
                mode == 2'b00 ? OUT_W'(1) << ip :
                mode == 2'b01 ? (OUT_W'(2) << ip) - OUT_W'(1) : rot;
  end
  assign in_ready = !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      out_valid <= 1'b0;
      op        <= '0;
      err       <= 1'b0;
      ring      <= OUT_W'(1);
    end else if (accept) begin
      out_valid <= 1'b1;
      op        <= code;
      err       <= bad;
      if (mode == 2'b10 && !range_err) ring <= rot;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// tb_onehot_encoder_pipe: directed plan plus random traffic checked against a behavioural model, for OUT_W=16 and OUT_W=10
module tb_onehot_encoder_pipe;
  logic        clk = 0;
  logic        rst = 1, clear = 0, in_valid = 0, out_ready = 0;
  logic [3:0]  ip = 0;
  logic [1:0]  mode = 0;
  logic        rdy16, ov16, err16, rdy10, ov10, err10;
  logic [15:0] op16, ring16;
  logic [9:0]  op10, ring10;
  int errors = 0, checks = 0;
  logic        mv[2], me[2];
  logic [15:0] mo[2], mr[2];
  int          wid[2] = '{16, 10};

  always #5 clk = ~clk;

  onehot_encoder_pipe u16 (.clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy16),
    .ip(ip), .mode(mode), .out_valid(ov16), .out_ready(out_ready), .op(op16), .err(err16), .ring(ring16));
  onehot_encoder_pipe #(.IN_W(4), .OUT_W(10)) u10 (.clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_ready(rdy10), .ip(ip), .mode(mode), .out_valid(ov10), .out_ready(out_ready), .op(op10), .err(err10),
    .ring(ring10));

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic logic model_ready(input int d);
    return !clear && (!mv[d] || out_ready);
  endfunction

  task automatic model_step(input int d);
    int          w = wid[d];
    logic [15:0] mk = 16'((32'd1 << w) - 1);
    logic        rd = model_ready(d);
    logic        re = int'(ip) >= w;
    if (rst || clear) begin
      mv[d] = 0; mo[d] = 0; me[d] = 0; mr[d] = 1;
    end else if (in_valid && rd) begin
      mv[d] = 1;
      me[d] = re || mode == 3;
      if (re || mode == 3) mo[d] = 0;
      else if (mode == 0) mo[d] = 16'(32'd1 << ip);
      else if (mode == 1) mo[d] = 16'((32'd1 << (int'(ip) + 1)) - 1);
      else begin
        for (int k = 0; k < int'(ip); k++) mr[d] = ((mr[d] << 1) | 16'(mr[d][w-1])) & mk;
        mo[d] = mr[d];
      end
    end else if (out_ready) mv[d] = 0;
  endtask

  task automatic cyc(input logic r, input logic c, input logic v, input logic [3:0] i,
                     input logic [1:0] md, input logic ordy);
    @(negedge clk);
    rst = r; clear = c; in_valid = v; ip = i; mode = md; out_ready = ordy;
    #1;
    chk("in_ready16", 32'(rdy16), 32'(model_ready(0)));
    chk("in_ready10", 32'(rdy10), 32'(model_ready(1)));
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    chk("out_valid16", 32'(ov16), 32'(mv[0]));
    chk("ring16", 32'(ring16), 32'(mr[0]));
    chk("out_valid10", 32'(ov10), 32'(mv[1]));
    chk("ring10", 32'(ring10), 32'(mr[1]));
    if (mv[0]) begin
      chk("op16", 32'(op16), 32'(mo[0]));
      chk("err16", 32'(err16), 32'(me[0]));
    end
    if (mv[1]) begin
      chk("op10", 32'(op10), 32'(mo[1]));
      chk("err10", 32'(err10), 32'(me[1]));
    end
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 1);
    chk("rst_valid", 32'(ov16), 0);
    chk("rst_op", 32'(op16), 0);
    chk("rst_ring", 32'(ring16), 32'h0001);
    chk("rst_in_ready", 32'(rdy16), 1);
    cyc(0, 0, 1, 5, 0, 1);
    chk("onehot5_op", 32'(op16), 32'h0020);
    chk("onehot5_err", 32'(err16), 0);
    cyc(0, 0, 1, 3, 1, 1);
    chk("therm3", 32'(op16), 32'h000F);
    cyc(0, 0, 1, 15, 1, 1);
    chk("therm15", 32'(op16), 32'hFFFF);
    chk("therm15_valid", 32'(ov16), 1);
    chk("therm15_err10", 32'(err10), 1);
    cyc(0, 0, 1, 3, 2, 1);
    chk("ring3", 32'(op16), 32'h0008);
    cyc(0, 0, 1, 4, 2, 1);
    chk("ring4", 32'(ring16), 32'h0080);
    cyc(0, 0, 1, 10, 2, 1);
    chk("ring10_wrap", 32'(op16), 32'h0002);
    cyc(0, 0, 1, 0, 2, 1);
    chk("ring0_op", 32'(op16), 32'h0002);
    cyc(0, 0, 1, 12, 0, 1);
    chk("w10_oor_op", 32'(op10), 0);
    chk("w10_oor_err", 32'(err10), 1);
    cyc(0, 0, 1, 11, 2, 1);
    chk("w10_ring_oor_op", 32'(op10), 0);
    chk("w10_ring_oor_err", 32'(err10), 1);
    chk("w10_ring_kept", 32'(ring10), 32'h080);
    cyc(0, 0, 1, 2, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 9, 0, 0);
      chk("bp_hold_op", 32'(op16), 32'h0004);
      chk("bp_in_ready", 32'(rdy16), 0);
    end
    cyc(0, 0, 1, 7, 0, 1);
    chk("bp_release_op", 32'(op16), 32'h0080);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 8, 2, 0);
    chk("ring_0100", 32'(ring16), 32'h0100);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 3, 0, 0);
    chk("clear_valid", 32'(ov16), 0);
    chk("clear_ring", 32'(ring16), 32'h0001);
    chk("clear_op", 32'(op16), 0);
    cyc(0, 0, 1, 8, 2, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 3, 0, 0);
    chk("rst_mid_valid", 32'(ov16), 0);
    chk("rst_mid_ring", 32'(ring16), 32'h0001);
    cyc(0, 0, 0, 0, 0, 0);
    chk("post_rst_ready", 32'(rdy16), 1);
    for (int n = 0; n < 400; n++)
      cyc($urandom_range(49) == 0, $urandom_range(19) == 0, $urandom_range(9) < 7,
          4'($urandom_range(15)), 2'($urandom_range(3)), $urandom_range(9) < 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/onehot_encoder_pipe.md
Name: onehot_encoder_pipe

Overview:
- Parametrised, pipelined successor to the combinational binary-to-one-hot encoder.
- Accepts a binary index under a valid/ready handshake and produces a registered code word, also under valid/ready.
- Three modes: one-hot decode, thermometer decode, and ring-rotate (stateful one-hot ring stepped by the index).
- Flags out-of-range indices.
- Sits between a producer of indices (arbiters, schedulers) and consumers needing select vectors.

Parameters:
- IN_W, 4, index width in bits.
- OUT_W, 16, code word width. Legal range 2..2**IN_W; elaboration error outside it.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous soft clear: ring to 1, output stage emptied; lower priority than rst.
- in_valid  input  1  index valid.
- in_ready  output  1  block can accept an index this cycle.
- ip  input  IN_W  binary index.
- mode  input  2  00 one-hot, 01 thermometer, 10 ring-rotate, 11 reserved.
- out_valid  output  1  op/err valid.
- out_ready  input  1  consumer accepts op.
- op  output  OUT_W  code word.
- err  output  1  index out of range or reserved mode, qualified by out_valid.
- ring  output  OUT_W  current ring state (always visible).

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, op=0, err=0, ring={OUT_W-1{0},1}. in_ready is 1 in the cycle after reset.
- Single output register stage.
  - in_ready = !out_valid || out_ready (combinational pass-through of out_ready).
  - Accept when in_valid && in_ready. Latency is 1 cycle: results appear on the next posedge.
- On accept: out_valid<=1, op and err computed from ip and mode.
- Out_valid drops only when out_valid && out_ready && !accept.
- Holding: while out_valid && !out_ready, op/err/out_valid are held stable and no input is accepted.
- Range check: range_err = (ip >= OUT_W). err = range_err || (mode==11).
- Mode 00, one-hot: op = 1<<ip. If range_err, op=0.
- Mode 01, thermometer: op bits [ip:0] set, others 0 (ip=0 gives 0...01). If range_err, op=0.
- Mode 10, ring-rotate:
  - next_ring = ring rotated left by ip (ip=0 gives an unchanged ring); op = next_ring; ring <= next_ring.
  - If range_err, ring is unchanged and op=0.
- Mode 11: op=0, err=1, ring unchanged.
- Ring updates only on an accepted mode-10 transaction; other modes never modify ring.
- clear=1 (rst=0):
  - ring<=1, out_valid<=0, op<=0, err<=0.
  - Any input presented that cycle is dropped, and in_ready is forced 0 during clear.
- rst mid-transaction: a pending output is discarded with no handshake completion. rst overrides clear and accept.
- Simultaneous out_ready handshake and new accept in the same cycle: the new word replaces the old one; out_valid stays 1 (full throughput, one word per cycle).
- Arithmetic: rotation amount is ip interpreted unsigned, and is always < OUT_W when applied. All comparisons are unsigned at width max(IN_W, clog2(OUT_W)+1).

Test Plan:
- Reset, then mode 00, ip=5, out_ready=1 → next cycle out_valid=1, op=16'h0020, err=0; ring=16'h0001.
- Mode 01, ip=3, then ip=15 back-to-back with out_ready=1 → op=16'h000F, then 16'hFFFF, on consecutive cycles with no bubble.
- Mode 10, ip sequence 3, 4, 10 → ring/op = 16'h0008, 16'h0080, 16'h0002 (wrap-around); then ip=0 → op=16'h0002.
- OUT_W=10, IN_W=4, mode 00, ip=12 → op=0, err=1; then mode 10, ip=11 → op=0, err=1, ring unchanged.
- Backpressure: out_ready=0 for 3 cycles after an accept of ip=2 → in_ready=0, op=16'h0004 held stable; on out_ready=1 with in_valid=1 (ip=7), op becomes 16'h0080 the next cycle.
- Ring at 16'h0100, pending output held, then clear=1 → next cycle out_valid=0, ring=16'h0001. Repeat with rst=1 → same result, and in_ready=1 after rst deasserts.
